com_tracker: RTL
================

Name: com_tracker

Overview:
- Produces the pressure centre-of-mass for the tactile grid and feeds the x_com/y_com inputs of the trail-overlay stage.
- Consumes the per-cell sample stream from the sensor scan controller.
- Accumulates thresholded weights over one scan frame, then divides sequentially.
- Emits pixel-space coordinates scaled by the same scale_in code used by the display path.

Parameters:
- SW_WIRE_CNT, 16, rows of the sensor grid (switched wires); must be ≤16.
- RD_WIRE_CNT, 16, columns of the sensor grid (read wires); must be ≤16.
- SAMPLE_W, 12, ADC sample width.
- THRESHOLD, 100, noise floor subtracted from every sample.
- MIN_WEIGHT, 256, minimum frame total weight for a valid centroid.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- sample_valid  in  1  sample_* fields valid this cycle
- sample_sw  in  4  row index of the sample
- sample_rd  in  4  column index of the sample
- sample_val  in  SAMPLE_W  raw ADC value
- frame_end  in  1  pulse marking the last sample of a scan frame; may coincide with sample_valid
- scale_in  in  2  pixel scale code: 00=×1, 01=×16, 10=×32, 11=×64
- x_com  out  11  centroid column, in pixels
- y_com  out  10  centroid row, in pixels
- com_valid  out  1  one-cycle pulse when x_com/y_com update
- com_present  out  1  level; last frame met MIN_WEIGHT
- overrun  out  1  sticky; a frame_end arrived while busy

Behaviour:
- Reset is asynchronous, active-high, on clk.
  - x_com, y_com, com_valid, com_present, overrun, all accumulators: 0.
  - FSM returns to ACCUM.
- Weight: w = sample_val − THRESHOLD if sample_val > THRESHOLD, else 0 (12-bit).
- Samples with sample_sw ≥ SW_WIRE_CNT or sample_rd ≥ RD_WIRE_CNT are ignored.
- Accumulators:
  - sum_w: 20 bits.
  - sum_wx = Σ w·rd and sum_wy = Σ w·sw: 24 bits each.
  - Widths are sized so 256 cells at full scale cannot overflow.
- FSM ACCUM:
  - Each valid sample adds into the accumulators.
  - On frame_end, the coincident sample is included. Totals are latched into the divider operands, the accumulators clear, and the FSM goes to DIVIDE.
- FSM DIVIDE:
  - Two parallel restoring dividers compute q = (sum_w{x,y} << 4) / sum_w.
  - Result is an 8-bit unsigned Q4.4 index; one quotient bit per cycle, 8 cycles.
  - Sample accumulation for the next frame continues in parallel.
  - Then go to OUTPUT.
- FSM OUTPUT (1 cycle):
  - If sum_w ≥ MIN_WEIGHT: x_com = (qx << s) >> 4 and y_com = (qy << s) >> 4, where s = 0/4/5/6 per scale_in; com_present=1.
  - Otherwise: x_com/y_com hold their previous values and com_present=0.
  - com_valid pulses in both cases. Return to ACCUM.
- scale_in is sampled in OUTPUT only.
- Latency: frame_end sampled at edge N → com_valid high after edge N+10, low after N+11.
- frame_end in DIVIDE or OUTPUT:
  - Set overrun (cleared only by rst).
  - Discard the frame being accumulated and clear the accumulators on that edge.
- sum_w == 0: divider is not started; behaves as below-MIN_WEIGHT.
- Results are truncated, not rounded. Arithmetic is unsigned throughout.

Optional Feature:
- Macro: COM_SMOOTH_EN.
- When defined:
  - A present result is blended in the Q4.4 domain: q_out = (q_prev + q_new + 1) >> 1.
  - The first present result after reset, or after a non-present frame, loads directly.
  - Adds no cycles of latency.
- When undefined: q_out = q_new and no history register exists.

Decomposition:
- Package com_tracker_pkg holds:
  - Enum state_t {ACCUM, DIVIDE, OUTPUT}.
  - Constants IDX_W=4, FRAC_W=4, Q_W=8, SUMW_W=20, SUMX_W=24.
  - A function scale_shift(scale_in) returning 0/4/5/6; the display path shares it.
- One sub-module, com_divider:
  - Restoring unsigned divider with parameterised numerator/quotient width.
  - start/busy/done handshake; done is one cycle.
  - Instantiated twice (x and y).

Test Plan:
- Single cell: sw=3, rd=5, val=1000, THRESHOLD=100, scale=01 → x_com=80, y_com=48, com_present=1; com_valid exactly 10 edges after frame_end.
- Two cells on row 2: rd=4 w=100, rd=5 w=300 (vals 200/400), scale=01 → qx=76, x_com=76.
  - scale=00 → x_com=4.
  - scale=10 → x_com=152.
- All samples ≤ THRESHOLD → com_valid pulses, com_present=0, x_com/y_com unchanged from the prior frame.
- frame_end reasserted 3 cycles after the first → overrun=1; that frame is dropped; the following full frame yields correct output.
- rst asserted mid-DIVIDE → all outputs 0 immediately; no com_valid afterwards until a new frame_end plus 10 edges.
- COM_SMOOTH_EN defined: present frames at x index 4.0 then 6.0, scale=00 → x_com 4 then 5.

Source files
------------

// File: rtl/com_tracker_pkg.sv
// Shared types and widths for the tactile centre-of-mass tracker and its display path.
package com_tracker_pkg;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DIVIDE = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    localparam int unsigned IDX_W  = 4;
    localparam int unsigned FRAC_W = 4;
    localparam int unsigned Q_W    = 8;
    localparam int unsigned SUMW_W = 20;
    localparam int unsigned SUMX_W = 24;

    // Pixel scale code to left-shift amount: x1, x16, x32, x64.
    function automatic logic [2:0] scale_shift(input logic [1:0] code);
        case (code)
            2'b00:   return 3'd0;
            2'b01:   return 3'd4;
            2'b10:   return 3'd5;
            default: return 3'd6;
        endcase
    endfunction

endpackage

// File: rtl/com_tracker_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; the quotient must fit in Q_W bits.
module com_divider #(
    parameter int unsigned NUM_W = 28,
    parameter int unsigned DEN_W = 20,
    parameter int unsigned Q_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             busy,
    output logic             done,
    output logic [Q_W-1:0]   quo
);

    localparam int unsigned REM_W = DEN_W + 1;
    localparam int unsigned CNT_W = $clog2(Q_W);

    logic [DEN_W-1:0] rem_q;
    logic [DEN_W-1:0] den_q;
    logic [Q_W-1:0]   lo_q;
    logic [CNT_W-1:0] cnt_q;
    logic [REM_W-1:0] trial_c;
    logic             ge_c;

    // Upper numerator bits are already below den, so only Q_W bits remain to shift in.
    assign trial_c = {rem_q, lo_q[Q_W-1]};
    assign ge_c    = (trial_c >= REM_W'(den_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            den_q <= '0;
            lo_q  <= '0;
            cnt_q <= '0;
            quo   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem_q <= DEN_W'(num[NUM_W-1:Q_W]);
                lo_q  <= num[Q_W-1:0];
                den_q <= den;
                cnt_q <= '0;
                quo   <= '0;
                busy  <= 1'b1;
            end else if (busy) begin
                rem_q <= ge_c ? DEN_W'(trial_c - REM_W'(den_q)) : DEN_W'(trial_c);
                lo_q  <= {lo_q[Q_W-2:0], 1'b0};
                quo   <= {quo[Q_W-2:0], ge_c};
                cnt_q <= cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(Q_W - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/com_tracker.sv
// Pressure centre-of-mass tracker: per-frame weighted sums, sequential divide, pixel scaling.
// Define COM_SMOOTH_EN to blend consecutive present results in the Q4.4 domain.
module com_tracker
    import com_tracker_pkg::*;
#(
    parameter int unsigned SW_WIRE_CNT = 16,
    parameter int unsigned RD_WIRE_CNT = 16,
    parameter int unsigned SAMPLE_W    = 12,
    parameter int unsigned THRESHOLD   = 100,
    parameter int unsigned MIN_WEIGHT  = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_valid,
    input  logic [IDX_W-1:0]    sample_sw,
    input  logic [IDX_W-1:0]    sample_rd,
    input  logic [SAMPLE_W-1:0] sample_val,
    input  logic                frame_end,
    input  logic [1:0]          scale_in,
    output logic [10:0]         x_com,
    output logic [9:0]          y_com,
    output logic                com_valid,
    output logic                com_present,
    output logic                overrun
);

    localparam int unsigned NUM_W = SUMX_W + FRAC_W;
    localparam int unsigned IDXC_W = IDX_W + 1;
    localparam int unsigned CNT_W = $clog2(Q_W + 1);
    localparam int unsigned PIX_W = Q_W + 6;

    state_t state_q, state_d;

    logic [SUMW_W-1:0] acc_w_q, acc_w_d, tot_w_c, add_w_c, den_q, den_d;
    logic [SUMX_W-1:0] acc_x_q, acc_x_d, tot_x_c, add_x_c;
    logic [SUMX_W-1:0] acc_y_q, acc_y_d, tot_y_c, add_y_c;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [Q_W-1:0]    qx_q, qx_d, qy_q, qy_d, qx_sel_c, qy_sel_c;
    logic [Q_W-1:0]    quo_x, quo_y;
    logic              busy_x, busy_y, done_x, done_y;
    logic              div_start_c, present_c, take_c;
    logic [SAMPLE_W-1:0] w_c;
    logic [PIX_W-1:0]  x_pix_c, y_pix_c;
    logic [10:0]       x_com_d;
    logic [9:0]        y_com_d;
    logic              com_valid_d, com_present_d, overrun_d;

`ifdef COM_SMOOTH_EN
    logic              hist_q, hist_d;
    logic [Q_W-1:0]    qx_prev_q, qx_prev_d, qy_prev_q, qy_prev_d;
    logic [Q_W:0]      blend_x_c, blend_y_c;
`endif

    // Thresholded weight of the current sample, gated by validity and grid bounds.
    always_comb begin
        w_c = (sample_val > SAMPLE_W'(THRESHOLD)) ? sample_val - SAMPLE_W'(THRESHOLD) : '0;
        take_c = sample_valid
               && ({1'b0, sample_sw} < IDXC_W'(SW_WIRE_CNT))
               && ({1'b0, sample_rd} < IDXC_W'(RD_WIRE_CNT));
        add_w_c = take_c ? SUMW_W'(w_c) : '0;
        add_x_c = take_c ? SUMX_W'(w_c) * SUMX_W'(sample_rd) : '0;
        add_y_c = take_c ? SUMX_W'(w_c) * SUMX_W'(sample_sw) : '0;
        tot_w_c = acc_w_q + add_w_c;
        tot_x_c = acc_x_q + add_x_c;
        tot_y_c = acc_y_q + add_y_c;
    end

    com_divider #(.NUM_W(NUM_W), .DEN_W(SUMW_W), .Q_W(Q_W)) u_div_x (
        .clk   (clk),
        .rst   (rst),
        .start (div_start_c),
        .num   ({tot_x_c, {FRAC_W{1'b0}}}),
        .den   (tot_w_c),
        .busy  (busy_x),
        .done  (done_x),
        .quo   (quo_x)
    );

    com_divider #(.NUM_W(NUM_W), .DEN_W(SUMW_W), .Q_W(Q_W)) u_div_y (
        .clk   (clk),
        .rst   (rst),
        .start (div_start_c),
        .num   ({tot_y_c, {FRAC_W{1'b0}}}),
        .den   (tot_w_c),
        .busy  (busy_y),
        .done  (done_y),
        .quo   (quo_y)
    );

    // Result selection in Q4.4, optionally blended with the previous present result.
    always_comb begin
`ifdef COM_SMOOTH_EN
        blend_x_c = {1'b0, qx_prev_q} + {1'b0, qx_q} + (Q_W+1)'(1);
        blend_y_c = {1'b0, qy_prev_q} + {1'b0, qy_q} + (Q_W+1)'(1);
        qx_sel_c  = hist_q ? Q_W'(blend_x_c >> 1) : qx_q;
        qy_sel_c  = hist_q ? Q_W'(blend_y_c >> 1) : qy_q;
`else
        qx_sel_c  = qx_q;
        qy_sel_c  = qy_q;
`endif
        x_pix_c   = PIX_W'(qx_sel_c) << scale_shift(scale_in);
        y_pix_c   = PIX_W'(qy_sel_c) << scale_shift(scale_in);
        present_c = (den_q != '0) && (den_q >= SUMW_W'(MIN_WEIGHT));
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        acc_w_d       = tot_w_c;
        acc_x_d       = tot_x_c;
        acc_y_d       = tot_y_c;
        den_d         = den_q;
        cnt_d         = cnt_q;
        qx_d          = done_x ? quo_x : qx_q;
        qy_d          = done_y ? quo_y : qy_q;
        x_com_d       = x_com;
        y_com_d       = y_com;
        com_valid_d   = 1'b0;
        com_present_d = com_present;
        overrun_d     = overrun;
        div_start_c   = 1'b0;
`ifdef COM_SMOOTH_EN
        hist_d        = hist_q;
        qx_prev_d     = qx_prev_q;
        qy_prev_d     = qy_prev_q;
`endif

        case (state_q)
            ACCUM: begin
                if (frame_end) begin
                    den_d       = tot_w_c;
                    div_start_c = (tot_w_c != '0);
                    acc_w_d     = '0;
                    acc_x_d     = '0;
                    acc_y_d     = '0;
                    cnt_d       = '0;
                    state_d     = DIVIDE;
                end
            end
            DIVIDE: begin
                if (cnt_q != CNT_W'(Q_W)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (!(busy_x || busy_y)) begin
                    state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                com_valid_d = 1'b1;
                state_d     = ACCUM;
                if (present_c) begin
                    x_com_d       = 11'(x_pix_c >> FRAC_W);
                    y_com_d       = 10'(y_pix_c >> FRAC_W);
                    com_present_d = 1'b1;
`ifdef COM_SMOOTH_EN
                    hist_d        = 1'b1;
                    qx_prev_d     = qx_sel_c;
                    qy_prev_d     = qy_sel_c;
`endif
                end else begin
                    com_present_d = 1'b0;
`ifdef COM_SMOOTH_EN
                    hist_d        = 1'b0;
`endif
                end
            end
            default: state_d = ACCUM;
        endcase

        // A frame boundary while the previous result is still in flight drops the new frame.
        if (frame_end && (state_q != ACCUM)) begin
            overrun_d = 1'b1;
            acc_w_d   = '0;
            acc_x_d   = '0;
            acc_y_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_w_q     <= '0;
            acc_x_q     <= '0;
            acc_y_q     <= '0;
            den_q       <= '0;
            cnt_q       <= '0;
            qx_q        <= '0;
            qy_q        <= '0;
            x_com       <= '0;
            y_com       <= '0;
            com_valid   <= 1'b0;
            com_present <= 1'b0;
            overrun     <= 1'b0;
`ifdef COM_SMOOTH_EN
            hist_q      <= 1'b0;
            qx_prev_q   <= '0;
            qy_prev_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            acc_w_q     <= acc_w_d;
            acc_x_q     <= acc_x_d;
            acc_y_q     <= acc_y_d;
            den_q       <= den_d;
            cnt_q       <= cnt_d;
            qx_q        <= qx_d;
            qy_q        <= qy_d;
            x_com       <= x_com_d;
            y_com       <= y_com_d;
            com_valid   <= com_valid_d;
            com_present <= com_present_d;
            overrun     <= overrun_d;
`ifdef COM_SMOOTH_EN
            hist_q      <= hist_d;
            qx_prev_q   <= qx_prev_d;
            qy_prev_q   <= qy_prev_d;
`endif
        end
    end

endmodule
